// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared state encoding and width helpers for the FIFO drain arbiter and its round-robin picker.
package fifo_drain_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int beat_w(input int maxburst);
    return (maxburst > 0) ? $clog2(maxburst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping modulo NCH.
// Zero latency; no handshake, o_found flags that any request was present.
module fifo_drain_arbiter_rr_pick
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = chan_w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_last,
  output logic [CW-1:0]  o_idx,
  output logic           o_found
);

  logic [NCH-1:0] w_rot;
  int             w_off;
  int             w_sum;

  // Rotate so bit 0 is channel last+1; the lowest set bit is then the winner's offset.
  always_comb begin
    w_rot   = NCH'({i_req, i_req} >> (int'(i_last) + 1));
    o_found = |i_req;
    w_off   = 0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = j;
    end
    w_sum = int'(i_last) + 1 + w_off;
    if (w_sum >= NCH) w_sum = w_sum - NCH;
    o_idx = CW'(w_sum);
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NCH FIFOs onto one registered valid/ready stream, grant held per packet/burst.
// First DEQ 1 clk after arbitration, O_VALID 1 clk after DEQ; no DEQ while the output beat is stalled.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int width    = 128,
  parameter int NCH      = 4,
  parameter int MAXBURST = 0,
  parameter int CW       = chan_w(NCH)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CLR,
  input  logic [NCH-1:0]       CH_EMPTY_N,
  input  logic [NCH*width-1:0] CH_DATA,
  input  logic [NCH-1:0]       CH_EOP,
  output logic [NCH-1:0]       CH_DEQ,
  output logic                 O_VALID,
  input  logic                 O_READY,
  output logic [width-1:0]     O_DATA,
  output logic                 O_EOP,
  output logic [CW-1:0]        O_CHAN,
  output logic                 GRANT_ACT
);

  localparam int BW = beat_w(MAXBURST);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_last;
  logic [CW-1:0]    r_grant;
  logic [BW-1:0]    r_beats;
  logic             r_valid;
  logic             r_eop;
  logic [CW-1:0]    r_chan;
  logic [width-1:0] r_data;

  logic [CW-1:0]    w_pick_idx;
  logic             w_pick_found;
  logic             w_sel_vld;
  logic             w_sel_eop;
  logic [width-1:0] w_sel_data;
  logic             w_fire;
  logic             w_burst_end;
  logic             w_release;

  fifo_drain_arbiter_rr_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_rr_pick (
    .i_req   (CH_EMPTY_N),
    .i_last  (r_last),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_sel_vld   = CH_EMPTY_N[r_grant];
  assign w_sel_eop   = CH_EOP[r_grant];
  assign w_sel_data  = CH_DATA[int'(r_grant)*width +: width];
  // CLR suppresses DEQ so no beat is popped into a register that is being cleared.
  assign w_fire      = (r_state == BUSY) && w_sel_vld && (!r_valid || O_READY) && !CLR;
  assign w_burst_end = (MAXBURST != 0) && (r_beats == BW'(MAXBURST - 1));
  assign w_release   = w_fire && (w_sel_eop || w_burst_end);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   r_state <= IDLE;
    else if (CLR) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_found) w_state_nxt = BUSY;
      BUSY:    if (w_release)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CH_DEQ = '0;
    if (w_fire) CH_DEQ[r_grant] = 1'b1;
    GRANT_ACT = (r_state == BUSY);
  end

  // last starts at NCH-1 so channel 0 wins the first arbitration after reset/clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last  <= CW'(NCH - 1);
      r_grant <= '0;
      r_beats <= '0;
    end else if (CLR) begin
      r_last  <= CW'(NCH - 1);
      r_grant <= '0;
      r_beats <= '0;
    end else if ((r_state == IDLE) && w_pick_found) begin
      r_grant <= w_pick_idx;
      r_beats <= '0;
    end else if (w_fire) begin
      r_beats <= r_beats + 1'b1;
      if (w_release) r_last <= r_grant;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid <= 1'b0;
      r_eop   <= 1'b0;
      r_chan  <= '0;
    end else if (CLR) begin
      r_valid <= 1'b0;
      r_eop   <= 1'b0;
      r_chan  <= '0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_eop   <= w_sel_eop;
      r_chan  <= r_grant;
    end else if (r_valid && O_READY) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fire) r_data <= w_sel_data;
  end

  assign O_VALID = r_valid;
  assign O_EOP   = r_eop;
  assign O_CHAN  = r_chan;
  assign O_DATA  = r_data;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench: two arbiters (unlimited burst and MAXBURST=2) fed from queue-modelled FIFOs, scoreboarded output.
module tb_fifo_drain_arbiter;

  localparam int W   = 32;
  localparam int NCH = 4;
  localparam int CW  = 2;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic          eop;
    logic [W-1:0]  data;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic           clr;
  logic [NCH-1:0] empty_n [2];
  logic [NCH*W-1:0] data_i [2];
  logic [NCH-1:0] eop_i   [2];
  logic [NCH-1:0] deq     [2];
  logic           o_valid [2];
  logic           o_ready [2];
  logic           o_eop   [2];
  logic           gact    [2];
  logic [W-1:0]   o_data  [2];
  logic [CW-1:0]  o_chan  [2];

  beat_t fq [2][NCH][$];
  beat_t exp_q [2][$];

  int n_checks = 0;
  int n_errors = 0;

  fifo_drain_arbiter #(.width(W), .NCH(NCH), .MAXBURST(0)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .CH_EMPTY_N(empty_n[0]), .CH_DATA(data_i[0]), .CH_EOP(eop_i[0]), .CH_DEQ(deq[0]),
    .O_VALID(o_valid[0]), .O_READY(o_ready[0]), .O_DATA(o_data[0]), .O_EOP(o_eop[0]),
    .O_CHAN(o_chan[0]), .GRANT_ACT(gact[0])
  );

  fifo_drain_arbiter #(.width(W), .NCH(NCH), .MAXBURST(2)) u_dut_mb (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .CH_EMPTY_N(empty_n[1]), .CH_DATA(data_i[1]), .CH_EOP(eop_i[1]), .CH_DEQ(deq[1]),
    .O_VALID(o_valid[1]), .O_READY(o_ready[1]), .O_DATA(o_data[1]), .O_EOP(o_eop[1]),
    .O_CHAN(o_chan[1]), .GRANT_ACT(gact[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_inputs();
    for (int d = 0; d < 2; d++) begin
      empty_n[d] = '0;
      eop_i[d]   = '0;
      data_i[d]  = '0;
      for (int k = 0; k < NCH; k++) begin
        if (fq[d][k].size() != 0) begin
          empty_n[d][k]       = 1'b1;
          eop_i[d][k]         = fq[d][k][0].eop;
          data_i[d][k*W +: W] = fq[d][k][0].data;
        end
      end
    end
  endtask

  task automatic load(input int d, input int k, input int n, input bit eop_last, input bit push_exp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.chan = CW'(k);
      b.data = $urandom;
      b.eop  = eop_last && (i == n - 1);
      fq[d][k].push_back(b);
      if (push_exp) exp_q[d].push_back(b);
    end
  endtask

  // Called at the negedge: check DEQ legality and output transfers, clock once, pop DEQ'd FIFOs.
  task automatic step();
    logic [NCH-1:0] dq [2];
    beat_t got;
    beat_t exp;
    for (int d = 0; d < 2; d++) begin
      dq[d] = deq[d];
      n_checks++;
      if (((deq[d] & ~empty_n[d]) != 0) || !$onehot0(deq[d]) ||
          ((deq[d] != 0) && o_valid[d] && !o_ready[d])) begin
        n_errors++;
        $display("FAIL deq_legal dut%0d: deq=%b empty_n=%b valid=%b ready=%b",
                 d, deq[d], empty_n[d], o_valid[d], o_ready[d]);
      end
      if (o_valid[d] === 1'b1 && o_ready[d] === 1'b1) begin
        n_checks++;
        got.chan = o_chan[d];
        got.eop  = o_eop[d];
        got.data = o_data[d];
        if (exp_q[d].size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat dut%0d: got chan=%0d eop=%b data=%h, expected none",
                   d, got.chan, got.eop, got.data);
        end else begin
          exp = exp_q[d].pop_front();
          if (got !== exp) begin
            n_errors++;
            $display("FAIL beat dut%0d: got chan=%0d eop=%b data=%h, expected chan=%0d eop=%b data=%h",
                     d, got.chan, got.eop, got.data, exp.chan, exp.eop, exp.data);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NCH; k++)
        if (dq[d][k] && fq[d][k].size() != 0) void'(fq[d][k].pop_front());
    drive_inputs();
    @(negedge clk);
  endtask

  task automatic drain(input int d, input int budget);
    int n = 0;
    while (exp_q[d].size() != 0 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (exp_q[d].size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout dut%0d: %0d beats still pending, expected 0", d, exp_q[d].size());
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NCH; k++) fq[d][k].delete();
      exp_q[d].delete();
    end
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NCH; k++) load(d, k, 1, 1'b1, 1'b0);
    drive_inputs();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks += 5;
      if (o_valid[d] !== 1'b0) begin n_errors++; $display("FAIL reset_valid dut%0d: got %b, expected 0", d, o_valid[d]); end
      if (o_eop[d] !== 1'b0) begin n_errors++; $display("FAIL reset_eop dut%0d: got %b, expected 0", d, o_eop[d]); end
      if (o_chan[d] !== '0) begin n_errors++; $display("FAIL reset_chan dut%0d: got %0d, expected 0", d, o_chan[d]); end
      if (gact[d] !== 1'b0) begin n_errors++; $display("FAIL reset_grant dut%0d: got %b, expected 0", d, gact[d]); end
      if (deq[d] !== '0) begin n_errors++; $display("FAIL reset_deq dut%0d: got %b, expected 0000", d, deq[d]); end
    end
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [NCH-1:0] exp_deq [6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic           exp_v   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    load(0, 0, 3, 1'b1, 1'b1);
    drive_inputs();
    #1;
    for (int c = 0; c < 6; c++) begin
      n_checks += 2;
      if (deq[0] !== exp_deq[c]) begin
        n_errors++;
        $display("FAIL single_deq cycle %0d: got %b, expected %b", c, deq[0], exp_deq[c]);
      end
      if (o_valid[0] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL single_valid cycle %0d: got %b, expected %b", c, o_valid[0], exp_v[c]);
      end
      step();
    end
    drain(0, 10);
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] exp_deq [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                     4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic           exp_v   [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < NCH; k++) load(0, k, 1, 1'b1, 1'b1);
    drive_inputs();
    #1;
    for (int c = 0; c < 10; c++) begin
      n_checks += 2;
      if (deq[0] !== exp_deq[c]) begin
        n_errors++;
        $display("FAIL rr_deq cycle %0d: got %b, expected %b", c, deq[0], exp_deq[c]);
      end
      if (o_valid[0] !== exp_v[c]) begin
        n_errors++;
        $display("FAIL rr_valid cycle %0d: got %b, expected %b", c, o_valid[0], exp_v[c]);
      end
      step();
    end
    drain(0, 10);
  endtask

  task automatic test_maxburst();
    do_reset();
    load(1, 1, 6, 1'b1, 1'b0);
    load(1, 2, 1, 1'b1, 1'b0);
    exp_q[1].push_back(fq[1][1][0]);
    exp_q[1].push_back(fq[1][1][1]);
    exp_q[1].push_back(fq[1][2][0]);
    for (int i = 2; i < 6; i++) exp_q[1].push_back(fq[1][1][i]);
    drive_inputs();
    #1;
    drain(1, 60);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    load(0, 0, 5, 1'b1, 1'b1);
    held = fq[0][0][1].data;
    drive_inputs();
    #1;
    repeat (3) step();
    o_ready[0] = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_checks += 3;
      if (o_valid[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_valid cycle %0d: got %b, expected 1", c, o_valid[0]);
      end
      if (o_data[0] !== held) begin
        n_errors++;
        $display("FAIL stall_data cycle %0d: got %h, expected %h", c, o_data[0], held);
      end
      if (deq[0] !== '0) begin
        n_errors++;
        $display("FAIL stall_deq cycle %0d: got %b, expected 0000", c, deq[0]);
      end
      step();
    end
    o_ready[0] = 1'b1;
    #1;
    drain(0, 20);
  endtask

  task automatic test_starved_grant();
    do_reset();
    load(0, 3, 2, 1'b0, 1'b1);
    drive_inputs();
    #1;
    step();
    load(0, 0, 2, 1'b1, 1'b0);
    drive_inputs();
    #1;
    repeat (2) step();
    for (int c = 0; c < 4; c++) begin
      n_checks += 2;
      if (gact[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL starve_grant cycle %0d: got %b, expected 1", c, gact[0]);
      end
      if (deq[0] !== '0) begin
        n_errors++;
        $display("FAIL starve_deq cycle %0d: got %b, expected 0000", c, deq[0]);
      end
      step();
    end
    load(0, 3, 2, 1'b1, 1'b1);
    exp_q[0].push_back(fq[0][0][0]);
    exp_q[0].push_back(fq[0][0][1]);
    drive_inputs();
    #1;
    drain(0, 30);
  endtask

  task automatic test_async_reset();
    do_reset();
    load(0, 2, 4, 1'b1, 1'b1);
    drive_inputs();
    #1;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (o_valid[0] !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %b, expected 0", o_valid[0]); end
    if (gact[0] !== 1'b0) begin n_errors++; $display("FAIL arst_grant: got %b, expected 0", gact[0]); end
    if (deq[0] !== '0) begin n_errors++; $display("FAIL arst_deq: got %b, expected 0000", deq[0]); end
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(0, 0, 1, 1'b1, 1'b1);
    for (int i = 0; i < fq[0][2].size(); i++) exp_q[0].push_back(fq[0][2][i]);
    drive_inputs();
    #1;
    step();
    n_checks += 2;
    if (gact[0] !== 1'b1) begin n_errors++; $display("FAIL arst_regrant: got %b, expected 1", gact[0]); end
    if (deq[0] !== 4'b0001) begin n_errors++; $display("FAIL arst_first_ch: got %b, expected 0001", deq[0]); end
    drain(0, 30);
  endtask

  task automatic test_clear();
    do_reset();
    load(0, 1, 3, 1'b1, 1'b1);
    drive_inputs();
    #1;
    repeat (2) step();
    o_ready[0] = 1'b0;
    clr        = 1'b1;
    #1;
    step();
    clr = 1'b0;
    n_checks += 2;
    if (o_valid[0] !== 1'b0) begin n_errors++; $display("FAIL clr_valid: got %b, expected 0", o_valid[0]); end
    if (gact[0] !== 1'b0) begin n_errors++; $display("FAIL clr_grant: got %b, expected 0", gact[0]); end
    o_ready[0] = 1'b1;
    exp_q[0].delete();
    load(0, 0, 1, 1'b1, 1'b1);
    for (int i = 0; i < fq[0][1].size(); i++) exp_q[0].push_back(fq[0][1][i]);
    drive_inputs();
    #1;
    step();
    n_checks++;
    if (deq[0] !== 4'b0001) begin n_errors++; $display("FAIL clr_first_ch: got %b, expected 0001", deq[0]); end
    drain(0, 30);
  endtask

  initial begin
    rst_n      = 1'b0;
    clr        = 1'b0;
    o_ready[0] = 1'b1;
    o_ready[1] = 1'b1;
    drive_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_maxburst();
    test_backpressure();
    test_starved_grant();
    test_async_reset();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
